counter_display_driver: RTL

//  Downstream consumer of up_down_counter: takes the 16-bit counter value and shows it
//  in decimal on a 5-digit multiplexed common-anode 7-segment display.

---
 rtl/counter_display_driver.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/counter_display_driver.sv
// Binary counter value -> BCD via 16-step double-dabble FSM, shown on a 5-digit
// multiplexed 7-segment display. BCD latency is 17 cycles; the scanner free-runs and never stalls.
module counter_display_driver #(
    parameter int REFRESH_DIV    = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] counter,
    output logic [19:0] bcd,
    output logic        busy,
    output logic [4:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [15:0]   snap_q, snap_d;
    logic [35:0]   work_q, work_d;
    logic [35:0]   adj;
    logic [3:0]    cnt_q, cnt_d;
    logic [19:0]   bcd_q, bcd_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [2:0]    idx_q, idx_d;

    logic [3:0]    nib;
    logic          upper_zero;
    logic          blank;
    logic [4:0]    an_h;
    logic [6:0]    seg_h;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            snap_q  <= 16'd0;
            work_q  <= 36'd0;
            cnt_q   <= 4'd0;
            bcd_q   <= 20'd0;
            rcnt_q  <= '0;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            rcnt_q  <= rcnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        adj     = work_q;
        // Nibbles only ever reach 9 before adjust, so a 4-bit +3 cannot wrap.
        for (int i = 0; i < 5; i++) begin
            if (work_q[16+4*i +: 4] >= 4'd5)
                adj[16+4*i +: 4] = work_q[16+4*i +: 4] + 4'd3;
        end
        case (state_q)
            IDLE: begin
                if (counter != snap_q) begin
                    snap_d  = counter;
                    work_d  = {20'd0, counter};
                    cnt_d   = 4'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = adj << 1;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd15)
                    state_d = DONE;
            end
            DONE: begin
                bcd_d   = work_q[35:16];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rcnt_d = rcnt_q + RW'(1);
        idx_d  = idx_q;
        if (rcnt_q == RMAX) begin
            rcnt_d = '0;
            idx_d  = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // Display path depends only on idx_q and bcd_q, so it cannot glitch with the FSM.
    always_comb begin
        nib        = 4'd0;
        upper_zero = 1'b0;
        case (idx_q)
            3'd0: begin nib = bcd_q[3:0];   upper_zero = 1'b0;                end
            3'd1: begin nib = bcd_q[7:4];   upper_zero = (bcd_q[19:4]  == 16'd0); end
            3'd2: begin nib = bcd_q[11:8];  upper_zero = (bcd_q[19:8]  == 12'd0); end
            3'd3: begin nib = bcd_q[15:12]; upper_zero = (bcd_q[19:12] == 8'd0);  end
            3'd4: begin nib = bcd_q[19:16]; upper_zero = (bcd_q[19:16] == 4'd0);  end
            default: begin nib = 4'd0; upper_zero = 1'b0; end
        endcase
    end

    always_comb begin
        blank = BLANK_LZ && upper_zero;
        an_h  = blank ? 5'd0 : (5'b00001 << idx_q);
        seg_h = 7'h00;
        if (!blank) begin
            case (nib)
                4'd0: seg_h = 7'h3F;
                4'd1: seg_h = 7'h06;
                4'd2: seg_h = 7'h5B;
                4'd3: seg_h = 7'h4F;
                4'd4: seg_h = 7'h66;
                4'd5: seg_h = 7'h6D;
                4'd6: seg_h = 7'h7D;
                4'd7: seg_h = 7'h07;
                4'd8: seg_h = 7'h7F;
                4'd9: seg_h = 7'h6F;
                default: seg_h = 7'h00;
            endcase
        end
    end

    assign bcd  = bcd_q;
    assign busy = (state_q != IDLE);
    assign an   = AN_ACTIVE_LOW  ? ~an_h  : an_h;
    assign seg  = SEG_ACTIVE_LOW ? ~seg_h : seg_h;
    assign dp   = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;

endmodule
